// File: rtl/cpu_bus_responder_if.sv
// CPU memory-request bus plus the forwarded external bus, bundled for the responder.
// The responder sits on the slave side of both halves; the CPU/system side is the master.
interface cpu_bus_responder_if;
    logic [1:0]  t_cycle;
    logic        mem_enable;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_wait;
    logic        ext_req;
    logic        ext_write;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;

    modport master (
        output t_cycle, mem_enable, mem_write, mem_addr, mem_wdata, ext_ack, ext_rdata,
        input  mem_rdata, mem_wait, ext_req, ext_write, ext_addr, ext_wdata
    );

    modport slave (
        input  t_cycle, mem_enable, mem_write, mem_addr, mem_wdata, ext_ack, ext_rdata,
        output mem_rdata, mem_wait, ext_req, ext_write, ext_addr, ext_wdata
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// Memory-side responder: serves HRAM, IE and the boot-ROM disable register locally and
// forwards everything else to the external bus, stalling t_cycle at 3 until acknowledged.
module cpu_bus_responder #(
    parameter logic [15:0] HRAM_BASE  = 16'hFF80,
    parameter int unsigned HRAM_DEPTH = 127
) (
    input  logic                clk,
    input  logic                reset,
    cpu_bus_responder_if.slave  bus,
    output logic                boot_rom_mapped,
    output logic [7:0]          ie_reg
);

    localparam int unsigned IdxW = $clog2(HRAM_DEPTH);
    localparam logic [15:0] IeAddr   = 16'hFFFF;
    localparam logic [15:0] BootAddr = 16'hFF50;

    typedef enum logic [1:0] {StIdle, StInt, StExtWait} state_e;
    typedef enum logic [1:0] {TgtIe, TgtBoot, TgtHram, TgtExt} target_e;

    state_e      state_q, state_d;
    target_e     tgt_q, tgt_d;
    target_e     tgt_dec;
    logic [15:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        boot_q, boot_d;
    logic [7:0]  ie_q, ie_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_write_q, ext_write_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;

    logic [7:0]      hram_q [HRAM_DEPTH];
    logic            hram_we;
    logic [IdxW-1:0] hram_idx;
    logic            hram_hit;
    logic            capture;

    // Range check done in 32 bits so BASE+DEPTH cannot wrap.
    assign hram_hit = ({16'h0, bus.mem_addr} >= {16'h0, HRAM_BASE}) &&
                      ({16'h0, bus.mem_addr} < ({16'h0, HRAM_BASE} + HRAM_DEPTH));
    assign hram_idx = IdxW'(addr_q - HRAM_BASE);
    assign capture  = (state_q == StIdle) && (bus.t_cycle == 2'd1) && bus.mem_enable;

    always_comb begin
        tgt_dec = TgtExt;
        if (bus.mem_addr == IeAddr) begin
            tgt_dec = TgtIe;
        end else if (bus.mem_addr == BootAddr) begin
            tgt_dec = TgtBoot;
        end else if (hram_hit) begin
            tgt_dec = TgtHram;
        end
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        boot_d      = boot_q;
        ie_d        = ie_q;
        ext_req_d   = ext_req_q;
        ext_write_d = ext_write_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        hram_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    tgt_d   = tgt_dec;
                    addr_d  = bus.mem_addr;
                    write_d = bus.mem_write;
                    wdata_d = bus.mem_wdata;
                    if (tgt_dec == TgtExt) begin
                        state_d     = StExtWait;
                        ext_req_d   = 1'b1;
                        ext_write_d = bus.mem_write;
                        ext_addr_d  = bus.mem_addr;
                        ext_wdata_d = bus.mem_wdata;
                    end else begin
                        state_d = StInt;
                    end
                end
            end
            StInt: begin
                unique case (tgt_q)
                    TgtIe: begin
                        if (write_q) ie_d = wdata_q;
                        else         rdata_d = ie_q;
                    end
                    TgtBoot: begin
                        // Disable is one-way: only a reset brings the overlay back.
                        if (write_q) begin
                            if (wdata_q != 8'h00) boot_d = 1'b0;
                        end else begin
                            rdata_d = 8'hFF;
                        end
                    end
                    TgtHram: begin
                        if (write_q) hram_we = 1'b1;
                        else         rdata_d = hram_q[hram_idx];
                    end
                    default: ;
                endcase
                state_d = StIdle;
            end
            StExtWait: begin
                if (bus.ext_ack) begin
                    ext_req_d = 1'b0;
                    if (!ext_write_q) rdata_d = bus.ext_rdata;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tgt_q       <= TgtExt;
            addr_q      <= 16'h0000;
            write_q     <= 1'b0;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'hFF;
            boot_q      <= 1'b1;
            ie_q        <= 8'h00;
            ext_req_q   <= 1'b0;
            ext_write_q <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            boot_q      <= boot_d;
            ie_q        <= ie_d;
            ext_req_q   <= ext_req_d;
            ext_write_q <= ext_write_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
        end
    end

    // HRAM contents survive reset.
    always_ff @(posedge clk) begin
        if (hram_we) hram_q[hram_idx] <= wdata_q;
    end

    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_wait   = (state_q == StExtWait) && (bus.t_cycle == 2'd3);
    assign bus.ext_req    = ext_req_q;
    assign bus.ext_write  = ext_write_q;
    assign bus.ext_addr   = ext_addr_q;
    assign bus.ext_wdata  = ext_wdata_q;
    assign boot_rom_mapped = boot_q;
    assign ie_reg          = ie_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: local targets, external forwarding, stall and reset.
module tb_cpu_bus_responder;

    logic       clk;
    logic       reset;
    logic       boot_rom_mapped;
    logic [7:0] ie_reg;
    int         total;
    int         bad;
    logic       ext_seen;
    logic       wait_seen;

    cpu_bus_responder_if bus_if ();

    cpu_bus_responder dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_if),
        .boot_rom_mapped (boot_rom_mapped),
        .ie_reg          (ie_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Machine-cycle pacer: free-running 0..3, frozen while mem_wait is high.
    always @(posedge clk) begin
        if (reset) bus_if.t_cycle <= 2'd0;
        else if (!bus_if.mem_wait) bus_if.t_cycle <= bus_if.t_cycle + 2'd1;
    end

    always @(posedge clk) begin
        if (bus_if.ext_req) ext_seen <= 1'b1;
        if (bus_if.mem_wait) wait_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request for the T1 capture edge; returns at the negedge of T2.
    task automatic cpu_req(input logic wr, input logic [15:0] addr, input logic [7:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.t_cycle != 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("tsync", {30'h0, bus_if.t_cycle}, 32'd1);
        bus_if.mem_enable = 1'b1;
        bus_if.mem_write  = wr;
        bus_if.mem_addr   = addr;
        bus_if.mem_wdata  = wd;
        @(negedge clk);
        bus_if.mem_enable = 1'b0;
    endtask

    task automatic cpu_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        cpu_req(1'b0, addr, 8'h00);
        @(negedge clk);
        chk(tag, {24'h0, bus_if.mem_rdata}, {24'h0, exp});
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] wd);
        cpu_req(1'b1, addr, wd);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ext_seen  = 1'b0;
        wait_seen = 1'b0;
        reset = 1'b1;
        bus_if.mem_enable = 1'b0;
        bus_if.mem_write  = 1'b0;
        bus_if.mem_addr   = 16'h0000;
        bus_if.mem_wdata  = 8'h00;
        bus_if.ext_ack    = 1'b0;
        bus_if.ext_rdata  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_rdata", {24'h0, bus_if.mem_rdata}, 32'hFF);
        chk("rst_wait", {31'h0, bus_if.mem_wait}, 32'd0);
        chk("rst_boot", {31'h0, boot_rom_mapped}, 32'd1);
        chk("rst_ie", {24'h0, ie_reg}, 32'h00);
        chk("rst_req", {31'h0, bus_if.ext_req}, 32'd0);
        chk("rst_ewr", {31'h0, bus_if.ext_write}, 32'd0);
        chk("rst_eaddr", {16'h0, bus_if.ext_addr}, 32'h0000);
        chk("rst_ewd", {24'h0, bus_if.ext_wdata}, 32'h00);
        reset = 1'b0;
        ext_seen  = 1'b0;
        wait_seen = 1'b0;

        cpu_rd("rd_ie", 16'hFFFF, 8'h00);
        cpu_rd("rd_boot", 16'hFF50, 8'hFF);
        chk("boot_on", {31'h0, boot_rom_mapped}, 32'd1);

        cpu_wr(16'hFF80, 8'h5A);
        cpu_wr(16'hFFFE, 8'hC3);
        cpu_rd("hram_lo", 16'hFF80, 8'h5A);
        cpu_rd("hram_hi", 16'hFFFE, 8'hC3);
        cpu_wr(16'hFF81, 8'h11);
        chk("wr_keeps_rdata", {24'h0, bus_if.mem_rdata}, 32'hC3);
        cpu_wr(16'hFFFF, 8'h1F);
        chk("ie_out", {24'h0, ie_reg}, 32'h1F);
        cpu_rd("rd_ie2", 16'hFFFF, 8'h1F);
        cpu_rd("hram_keep", 16'hFF80, 8'h5A);

        cpu_wr(16'hFF50, 8'h00);
        chk("boot_w0", {31'h0, boot_rom_mapped}, 32'd1);
        cpu_wr(16'hFF50, 8'h01);
        chk("boot_w1", {31'h0, boot_rom_mapped}, 32'd0);
        cpu_wr(16'hFF50, 8'h00);
        chk("boot_sticky", {31'h0, boot_rom_mapped}, 32'd0);
        chk("int_no_req", {31'h0, ext_seen}, 32'd0);
        chk("int_no_wait", {31'h0, wait_seen}, 32'd0);

        // Zero-wait external read
        cpu_req(1'b0, 16'hC123, 8'h00);
        chk("zw_req", {31'h0, bus_if.ext_req}, 32'd1);
        chk("zw_addr", {16'h0, bus_if.ext_addr}, 32'hC123);
        chk("zw_wr", {31'h0, bus_if.ext_write}, 32'd0);
        bus_if.ext_ack   = 1'b1;
        bus_if.ext_rdata = 8'h9E;
        @(negedge clk);
        bus_if.ext_ack = 1'b0;
        chk("zw_t3", {30'h0, bus_if.t_cycle}, 32'd3);
        chk("zw_rdata", {24'h0, bus_if.mem_rdata}, 32'h9E);
        chk("zw_req_off", {31'h0, bus_if.ext_req}, 32'd0);
        chk("zw_no_wait", {31'h0, wait_seen}, 32'd0);

        // Delayed external read
        cpu_req(1'b0, 16'h4000, 8'h00);
        chk("dl_req", {31'h0, bus_if.ext_req}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dl_wait", {31'h0, bus_if.mem_wait}, 32'd1);
            chk("dl_hold", {30'h0, bus_if.t_cycle}, 32'd3);
        end
        bus_if.ext_ack   = 1'b1;
        bus_if.ext_rdata = 8'h77;
        @(negedge clk);
        bus_if.ext_ack = 1'b0;
        chk("dl_req_off", {31'h0, bus_if.ext_req}, 32'd0);
        chk("dl_rdata", {24'h0, bus_if.mem_rdata}, 32'h77);
        chk("dl_wait_off", {31'h0, bus_if.mem_wait}, 32'd0);
        @(negedge clk);
        chk("dl_t0", {30'h0, bus_if.t_cycle}, 32'd0);

        // External write aborted by reset, then a late ack
        cpu_req(1'b1, 16'h2000, 8'h03);
        chk("rw_req", {31'h0, bus_if.ext_req}, 32'd1);
        chk("rw_wr", {31'h0, bus_if.ext_write}, 32'd1);
        chk("rw_addr", {16'h0, bus_if.ext_addr}, 32'h2000);
        chk("rw_wdata", {24'h0, bus_if.ext_wdata}, 32'h03);
        @(negedge clk);
        chk("rw_wait", {31'h0, bus_if.mem_wait}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_req_rst", {31'h0, bus_if.ext_req}, 32'd0);
        chk("rw_wait_rst", {31'h0, bus_if.mem_wait}, 32'd0);
        bus_if.ext_ack   = 1'b1;
        bus_if.ext_rdata = 8'hAA;
        @(negedge clk);
        bus_if.ext_ack = 1'b0;
        @(negedge clk);
        chk("late_rdata", {24'h0, bus_if.mem_rdata}, 32'hFF);
        chk("late_req", {31'h0, bus_if.ext_req}, 32'd0);
        chk("late_wait", {31'h0, bus_if.mem_wait}, 32'd0);
        chk("rst_boot2", {31'h0, boot_rom_mapped}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
